// File: rtl/auth_access_controller.sv
// auth_access_controller: samples the 3-bit comparator result on a request,
// resolves a privilege level, holds a timed grant or pulses a deny, and
// counts consecutive failures.
// Optional feature macro: AUTH_CTRL_LOCKOUT_EN enables the timed LOCK state
// entered after MAX_ATTEMPTS consecutive failures; without it, every failure
// goes to DENY and locked is tied low.
module auth_access_controller #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int GRANT_CYCLES = 8,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] aut,
  output logic       busy,
  output logic       granted,
  output logic [1:0] level,
  output logic       denied,
  output logic       locked,
  output logic [3:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_GRANT,
    S_DENY
`ifdef AUTH_CTRL_LOCKOUT_EN
    , S_LOCK
`endif
  } state_t;

  // Reject out-of-range parameters at elaboration time.
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 ||
      GRANT_CYCLES < 1 || GRANT_CYCLES > 255 ||
      LOCK_CYCLES  < 1 || LOCK_CYCLES  > 65535) begin : g_param_check
    $error("auth_access_controller: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [2:0] aut_q, aut_d;
  logic [7:0] grant_cnt_q, grant_cnt_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic [1:0] lvl_q, lvl_d;
  logic [1:0] resolved;
  logic [3:0] fail_inc;
  logic       busy_q, busy_d;
  logic       granted_q, granted_d;
  logic [1:0] level_q, level_d;
  logic       denied_q, denied_d;
`ifdef AUTH_CTRL_LOCKOUT_EN
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;
`endif

  // Priority-resolve the captured result and form the saturating failure count.
  always_comb begin
    resolved = 2'd0;
    if (aut_q[2])      resolved = 2'd3;
    else if (aut_q[1]) resolved = 2'd2;
    else if (aut_q[0]) resolved = 2'd1;
    fail_inc = (fail_cnt_q == 4'd15) ? 4'd15 : fail_cnt_q + 4'd1;
  end

  // Next-state logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    aut_d       = aut_q;
    grant_cnt_d = grant_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    lvl_d       = lvl_q;
`ifdef AUTH_CTRL_LOCKOUT_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          aut_d   = aut;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (resolved != 2'd0) begin
          fail_cnt_d  = 4'd0;
          grant_cnt_d = GRANT_CYCLES[7:0];
          lvl_d       = resolved;
          state_d     = S_GRANT;
        end else begin
          fail_cnt_d = fail_inc;
`ifdef AUTH_CTRL_LOCKOUT_EN
          if (fail_inc == MAX_ATTEMPTS[3:0]) begin
            lock_cnt_d = LOCK_CYCLES[15:0];
            state_d    = S_LOCK;
          end else begin
            state_d = S_DENY;
          end
`else
          state_d = S_DENY;
`endif
        end
      end
      S_GRANT: begin
        grant_cnt_d = grant_cnt_q - 8'd1;
        if (grant_cnt_q <= 8'd1) state_d = S_IDLE;
      end
      S_DENY: begin
        state_d = S_IDLE;
      end
`ifdef AUTH_CTRL_LOCKOUT_EN
      S_LOCK: begin
        lock_cnt_d = lock_cnt_q - 16'd1;
        if (lock_cnt_q <= 16'd1) begin
          fail_cnt_d = 4'd0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    granted_d = (state_d == S_GRANT);
    level_d   = (state_d == S_GRANT) ? lvl_d : 2'd0;
    denied_d  = (state_d == S_DENY);
`ifdef AUTH_CTRL_LOCKOUT_EN
    locked_d  = (state_d == S_LOCK);
`endif
  end

  // State, counters and registered outputs, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      aut_q       <= 3'd0;
      grant_cnt_q <= 8'd0;
      fail_cnt_q  <= 4'd0;
      lvl_q       <= 2'd0;
      busy_q      <= 1'b0;
      granted_q   <= 1'b0;
      level_q     <= 2'd0;
      denied_q    <= 1'b0;
`ifdef AUTH_CTRL_LOCKOUT_EN
      lock_cnt_q  <= 16'd0;
      locked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      aut_q       <= aut_d;
      grant_cnt_q <= grant_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      lvl_q       <= lvl_d;
      busy_q      <= busy_d;
      granted_q   <= granted_d;
      level_q     <= level_d;
      denied_q    <= denied_d;
`ifdef AUTH_CTRL_LOCKOUT_EN
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign granted  = granted_q;
  assign level    = level_q;
  assign denied   = denied_q;
  assign fail_cnt = fail_cnt_q;
`ifdef AUTH_CTRL_LOCKOUT_EN
  assign locked   = locked_q;
`else
  assign locked   = 1'b0;
`endif

endmodule

// File: tb/tb_auth_access_controller.sv
// Scoreboard bench for auth_access_controller: a transaction-level model
// predicts each response when a request is issued; a monitor pops and checks
// whenever granted/denied/locked rises.
module tb_auth_access_controller;

  localparam int MAX_ATT = 3;
  localparam int GRANT_C = 8;
  localparam int LOCK_C  = 16;
`ifdef AUTH_CTRL_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] aut;
  logic       busy, granted, denied, locked;
  logic [1:0] level;
  logic [3:0] fail_cnt;

  auth_access_controller #(
    .MAX_ATTEMPTS(MAX_ATT),
    .GRANT_CYCLES(GRANT_C),
    .LOCK_CYCLES (LOCK_C)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .aut     (aut),
    .busy    (busy),
    .granted (granted),
    .level   (level),
    .denied  (denied),
    .locked  (locked),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge E, cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // kind: 0 = grant, 1 = deny, 2 = lock
  typedef struct {
    int kind;
    int lvl;
    int fcnt;
    int start;
    int dur;
  } resp_t;

  resp_t exp_q[$];
  int    next_accept = 0;
  int    model_fails = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc + 1);
    end
  endtask

  // Reference model: a request accepted at edge n answers from cycle n+2.
  task automatic modelRequest(input logic [2:0] a, input int n);
    resp_t r;
    int lvl;
    lvl = 0;
    for (int i = 2; i >= 0; i--) begin
      if (a[i] && lvl == 0) lvl = i + 1;
    end
    r.start = n + 2;
    if (lvl != 0) begin
      model_fails = 0;
      r.kind = 0; r.lvl = lvl; r.fcnt = 0; r.dur = GRANT_C;
      next_accept = n + GRANT_C + 2;
    end else begin
      model_fails = (model_fails < 15) ? model_fails + 1 : 15;
      r.lvl = 0; r.fcnt = model_fails;
      if (LOCK_EN && model_fails == MAX_ATT) begin
        r.kind = 2; r.dur = LOCK_C;
        next_accept = n + LOCK_C + 2;
        model_fails = 0;
      end else begin
        r.kind = 1; r.dur = 1;
        next_accept = n + 3;
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic applyStimulus(input bit r, input logic [2:0] a);
    @(negedge clk);
    req = r;
    aut = a;
    if (r && (cyc + 1) >= next_accept) modelRequest(a, cyc + 1);
  endtask

  task automatic issueWhenReady(input logic [2:0] a);
    while (next_accept > cyc + 2) applyStimulus(1'b0, 3'($urandom_range(0, 7)));
    applyStimulus(1'b1, a);
  endtask

  // Monitor: pop on each response start, then track its length.
  bit    active = 1'b0;
  int    act_kind, act_len, obs_kind;
  logic  hi;
  resp_t cur;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (active) begin
        hi = (act_kind == 0) ? granted : (act_kind == 1) ? denied : locked;
        if (hi) begin
          act_len++;
          if (act_kind == 0) checkOutput("level_hold", int'(level), cur.lvl);
        end else begin
          active = 1'b0;
          checkOutput("duration", act_len, cur.dur);
          checkOutput("busy_after", int'(busy), 0);
          if (act_kind == 2) checkOutput("fail_cnt_after_lock", int'(fail_cnt), 0);
        end
      end else if (granted || denied || locked) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_response: got g=%0d d=%0d l=%0d expected none (cycle %0d)",
                   granted, denied, locked, cyc + 1);
        end else begin
          cur = exp_q.pop_front();
          obs_kind = granted ? 0 : (denied ? 1 : 2);
          checkOutput("kind", obs_kind, cur.kind);
          checkOutput("start_cycle", cyc + 1, cur.start);
          checkOutput("level", int'(level), (cur.kind == 0) ? cur.lvl : 0);
          checkOutput("fail_cnt", int'(fail_cnt), cur.fcnt);
          checkOutput("busy", int'(busy), 1);
          active   = 1'b1;
          act_kind = obs_kind;
          act_len  = 1;
        end
      end
    end
  end

  // Reset discards any in-flight expectation.
  always @(posedge rst) begin
    exp_q.delete();
    active = 1'b0;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    aut = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_granted", int'(granted), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_denied", int'(denied), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_fail_cnt", int'(fail_cnt), 0);
    #1 rst = 1'b0;

    // Level resolution and priority
    issueWhenReady(3'b010);
    issueWhenReady(3'b101);
    issueWhenReady(3'b001);

    // Three failures back-to-back, then requests while locked/busy
    issueWhenReady(3'b000);
    issueWhenReady(3'b000);
    issueWhenReady(3'b000);
    repeat (6) applyStimulus(1'b1, 3'b111);

    // Two failures, success clears, one more failure
    issueWhenReady(3'b000);
    issueWhenReady(3'b000);
    issueWhenReady(3'b100);
    issueWhenReady(3'b000);

    // Five consecutive failures
    repeat (5) issueWhenReady(3'b000);
    issueWhenReady(3'b011);

    // Reset in the middle of a grant
    issueWhenReady(3'b010);
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_granted", int'(granted), 0);
    checkOutput("midrst_level", int'(level), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_fail_cnt", int'(fail_cnt), 0);
    #1 rst = 1'b0;
    next_accept = 0;
    model_fails = 0;
    issueWhenReady(3'b010);

    // Randomized traffic, biased toward failures so lockouts occur
    for (int i = 0; i < 700; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7)));
    end

    // Drain outstanding responses within a bounded window
    begin
      int waited;
      waited = 0;
      while ((exp_q.size() != 0 || active) && waited < 80) begin
        applyStimulus(1'b0, 3'b000);
        waited++;
      end
      checks++;
      if (exp_q.size() != 0 || active) begin
        errors++;
        $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
